// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, types and writeback source enum for the register file writeback path
package rf_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write mask with set-wins update and two hazard query ports
// Optional forwarding qualification under RF_WB_BYPASS_EN.
module rf_scoreboard #(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW   = rf_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_rd,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [AW-1:0]   q1,
  input  logic [AW-1:0]   q2,
  output logic            busy1,
  output logic            busy2
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [XLEN-1:0] wr_data,
  output logic            fwd1_valid,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd2_data
`endif
);
  import rf_pkg::*;

  localparam int NR = 1 << AW;

  logic [NR-1:0] pending_q;
  logic [NR-1:0] pending_d;

  // Clear first so a same-edge reservation (new producer) keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (wr_en) pending_d[wr_addr] = 1'b0;
    if (rsv_valid) pending_d[rsv_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

`ifdef RF_WB_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1       = wr_en && (wr_addr == q1) && (q1 != '0);
  assign hit2       = wr_en && (wr_addr == q2) && (q2 != '0);
  assign busy1      = pending_q[q1] && !hit1;
  assign busy2      = pending_q[q2] && !hit2;
  assign fwd1_valid = hit1;
  assign fwd2_valid = hit2;
  assign fwd1_data  = wr_data;
  assign fwd2_data  = wr_data;
`else
  assign busy1 = pending_q[q1];
  assign busy2 = pending_q[q2];
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin ALU/LSU arbiter for the register file write port plus hazard scoreboard
// RF_WB_BYPASS_EN adds forwarding outputs and early busy release in the write cycle.
module rf_wb_arbiter #(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW   = rf_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_rd,
  input  logic [AW-1:0]   q1,
  input  logic [AW-1:0]   q2,
  output logic            busy1,
  output logic            busy2,
`ifdef RF_WB_BYPASS_EN
  output logic            fwd1_valid,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd2_data,
`endif
  output logic            we3,
  output logic [AW-1:0]   a3,
  output logic [XLEN-1:0] wd3
);
  import rf_pkg::*;

  // Requester that wins when both are valid.
  wb_src_e         prio_q;
  logic            xfer;
  logic [AW-1:0]   xfer_rd;
  logic [XLEN-1:0] xfer_data;

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (rst_n) begin
      if (alu_valid && (!lsu_valid || prio_q == WB_ALU)) alu_ready = 1'b1;
      else if (lsu_valid)                                 lsu_ready = 1'b1;
    end
  end

  assign xfer      = alu_ready || lsu_ready;
  assign xfer_rd   = alu_ready ? alu_rd   : lsu_rd;
  assign xfer_data = alu_ready ? alu_data : lsu_data;

  // x0 transfers are accepted but never reach the write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= WB_ALU;
      we3    <= 1'b0;
      a3     <= '0;
      wd3    <= '0;
    end else begin
      if (alu_ready)      prio_q <= WB_LSU;
      else if (lsu_ready) prio_q <= WB_ALU;
      we3 <= xfer && (xfer_rd != '0);
      if (xfer && (xfer_rd != '0)) begin
        a3  <= xfer_rd;
        wd3 <= xfer_data;
      end
    end
  end

  rf_scoreboard #(.XLEN(XLEN), .AW(AW)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsv_valid  (rsv_valid),
    .rsv_rd     (rsv_rd),
    .wr_en      (we3),
    .wr_addr    (a3),
    .q1         (q1),
    .q2         (q2),
    .busy1      (busy1),
    .busy2      (busy2)
`ifdef RF_WB_BYPASS_EN
    ,
    .wr_data    (wd3),
    .fwd1_valid (fwd1_valid),
    .fwd1_data  (fwd1_data),
    .fwd2_valid (fwd2_valid),
    .fwd2_data  (fwd2_data)
`endif
  );

endmodule
